// File: rtl/dmac_main_ctrl_nch_if.sv
// dmac_main_ctrl_nch_if: peripheral request/ack and AHB descriptor-fetch signals of the DMAC main controller
//   DmacReq/ReqAck          peripheral request levels and one-cycle acknowledge
//   Bus_Req/Bus_Grant       AHB arbiter handshake
//   HReady                  AHB ready
//   config_HTrans           descriptor-fetch HTRANS (Idle=00, Busy=01, Non_Seq=10)
//   addr_inc_sel/desc_we    descriptor word index and one-hot register load enables
interface dmac_main_ctrl_nch_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] DmacReq;
    logic [NUM_CH-1:0] ReqAck;
    logic              Bus_Req;
    logic              Bus_Grant;
    logic              HReady;
    logic [1:0]        config_HTrans;
    logic [1:0]        addr_inc_sel;
    logic [3:0]        desc_we;

    modport master (
        input  DmacReq, Bus_Grant, HReady,
        output ReqAck, Bus_Req, config_HTrans, addr_inc_sel, desc_we
    );

    modport slave (
        output DmacReq, Bus_Grant, HReady,
        input  ReqAck, Bus_Req, config_HTrans, addr_inc_sel, desc_we
    );
endinterface

// File: rtl/dmac_main_ctrl_nch.sv
// dmac_main_ctrl_nch: N-channel DMAC main controller (arbitration, descriptor fetch, suspend/resume, irq)
//   clk, rst   clock and asynchronous active-low reset
//   bus        request/ack and AHB descriptor-fetch signals
//   ch_done    selected channel finished its transfer
//   ch_sel     latched winning channel
//   ch_en      one-hot enable of the channel being transferred
//   Interrupt  one-cycle completion pulse, irq_ch names its channel
//   busy       controller is not idle
module dmac_main_ctrl_nch #(
    parameter  int NUM_CH   = 4,
    parameter  int ARB_MODE = 0,
    localparam int CH_W     = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst,
    dmac_main_ctrl_nch_if.master bus,
    input  logic                ch_done,
    output logic [CH_W-1:0]     ch_sel,
    output logic [NUM_CH-1:0]   ch_en,
    output logic                Interrupt,
    output logic [CH_W-1:0]     irq_ch,
    output logic                busy
);
    typedef enum logic [2:0] {IDLE, BUS_REQD, FETCH, XFER, SUSPEND} state_t;

    state_t                state, state_n;
    logic [2:0]            idx, idx_n;
    logic [CH_W-1:0]       win, last_served, irq_q;
    logic                  acked;
    logic [NUM_CH-1:0]     sel_oh;
    logic [2*NUM_CH-1:0]   dbl;

    assign sel_oh      = {{(NUM_CH-1){1'b0}}, 1'b1} << ch_sel;
    assign dbl         = {bus.DmacReq, bus.DmacReq};
    assign bus.Bus_Req = state != IDLE;
    assign busy        = state != IDLE;
    assign ch_en       = state == XFER ? sel_oh : '0;
    assign irq_ch      = Interrupt ? ch_sel : irq_q;

    // Round-robin scans the doubled request vector downward so the last hit is
    // the first set bit above last_served, wrapping past NUM_CH-1.
    always_comb begin
        win = '0;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < NUM_CH; i++)
                if (bus.DmacReq[i]) win = CH_W'(i);
        end else begin
            for (int i = 2*NUM_CH-1; i >= 0; i--)
                if (dbl[i] && i > int'(last_served) && i <= int'(last_served) + NUM_CH)
                    win = CH_W'(i % NUM_CH);
        end
    end

    always_comb begin
        state_n           = state;
        idx_n             = idx;
        bus.ReqAck        = '0;
        bus.config_HTrans = 2'b00;
        bus.addr_inc_sel  = 2'd0;
        bus.desc_we       = 4'b0000;
        Interrupt         = 1'b0;
        case (state)
            IDLE: if (|bus.DmacReq) state_n = BUS_REQD;
            BUS_REQD: if (bus.Bus_Grant && bus.HReady) begin
                bus.ReqAck = acked ? '0 : sel_oh;
                idx_n      = 3'd0;
                state_n    = FETCH;
            end
            FETCH: if (!bus.Bus_Grant) begin
                idx_n   = 3'd0;
                state_n = BUS_REQD;
            end else begin
                // Address phase of word idx overlaps the data phase of word idx-1.
                bus.addr_inc_sel  = idx[2] ? 2'd3 : idx[1:0];
                bus.config_HTrans = !bus.HReady ? 2'b01 : idx[2] ? 2'b00 : 2'b10;
                if (bus.HReady) begin
                    bus.desc_we = idx == 3'd0 ? 4'b0000 : 4'b0001 << (idx - 3'd1);
                    idx_n       = idx[2] ? idx : idx + 3'd1;
                    state_n     = idx[2] ? XFER : FETCH;
                end
            end
            XFER: if (ch_done) begin
                Interrupt = 1'b1;
                state_n   = IDLE;
            end else if (!bus.Bus_Grant) begin
                state_n = SUSPEND;
            end
            SUSPEND: if (bus.Bus_Grant) state_n = XFER;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= 3'd0;
            ch_sel      <= '0;
            irq_q       <= '0;
            last_served <= CH_W'(NUM_CH - 1);
            acked       <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (state == IDLE && |bus.DmacReq) begin
                ch_sel <= win;
                acked  <= 1'b0;
            end
            // A fetch restart after grant loss must not acknowledge the peripheral twice.
            if (state == BUS_REQD && bus.Bus_Grant && bus.HReady) acked <= 1'b1;
            if (Interrupt) begin
                irq_q       <= ch_sel;
                last_served <= ch_sel;
            end
        end
    end
endmodule

// File: tb/tb_dmac_main_ctrl_nch.sv
// tb_dmac_main_ctrl_nch: scoreboard bench for a fixed-priority and a round-robin controller instance
module tb_dmac_main_ctrl_nch;
    localparam int K_BR = 0, K_ACK = 1, K_NS = 2, K_BUSY = 3, K_WE = 4, K_EN = 5, K_IRQ = 6, K_SNAP = 7;

    typedef struct {
        int d;
        int k;
        int v;
        int gap;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] req [2];
    logic       grant [2];
    logic       hready [2];
    logic       done [2];
    logic       snap [2];
    logic       on, fin;

    logic [1:0] sel [2];
    logic [1:0] irq [2];
    logic [3:0] en [2];
    logic       intr [2];
    logic       bsy [2];
    logic       br [2];
    logic [3:0] ack [2];
    logic [3:0] we [2];
    logic [1:0] ht [2];
    logic [1:0] ai [2];

    dmac_main_ctrl_nch_if #(.NUM_CH(4)) b0 ();
    dmac_main_ctrl_nch_if #(.NUM_CH(4)) b1 ();

    assign b0.DmacReq   = req[0];
    assign b0.Bus_Grant = grant[0];
    assign b0.HReady    = hready[0];
    assign b1.DmacReq   = req[1];
    assign b1.Bus_Grant = grant[1];
    assign b1.HReady    = hready[1];
    assign br[0]  = b0.Bus_Req;
    assign ack[0] = b0.ReqAck;
    assign we[0]  = b0.desc_we;
    assign ht[0]  = b0.config_HTrans;
    assign ai[0]  = b0.addr_inc_sel;
    assign br[1]  = b1.Bus_Req;
    assign ack[1] = b1.ReqAck;
    assign we[1]  = b1.desc_we;
    assign ht[1]  = b1.config_HTrans;
    assign ai[1]  = b1.addr_inc_sel;

    dmac_main_ctrl_nch #(.NUM_CH(4), .ARB_MODE(0)) u_fix (
        .clk(clk), .rst(rst), .bus(b0), .ch_done(done[0]), .ch_sel(sel[0]),
        .ch_en(en[0]), .Interrupt(intr[0]), .irq_ch(irq[0]), .busy(bsy[0])
    );

    dmac_main_ctrl_nch #(.NUM_CH(4), .ARB_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .bus(b1), .ch_done(done[1]), .ch_sel(sel[1]),
        .ch_en(en[1]), .Interrupt(intr[1]), .irq_ch(irq[1]), .busy(bsy[1])
    );

    ev_t  q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last [2] = '{0, 0};
    logic pbr [2] = '{1'b0, 1'b0};
    logic [3:0] pen [2] = '{4'd0, 4'd0};

    function automatic string kname(int k);
        case (k)
            K_BR:    return "bus_req";
            K_ACK:   return "req_ack";
            K_NS:    return "nonseq_addr";
            K_BUSY:  return "busy_addr";
            K_WE:    return "desc_we";
            K_EN:    return "ch_en";
            K_IRQ:   return "irq_ch";
            default: return "snapshot";
        endcase
    endfunction

    function automatic int pk(int d);
        return int'({sel[d], irq[d], intr[d], bsy[d], br[d], ack[d], en[d], we[d], ht[d], ai[d]});
    endfunction

    task automatic see(int d, int k, int v);
        ev_t e;
        int  g;
        g = cyc - last[d];
        last[d] = cyc;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected d%0d %s: got v=%0h, none expected", d, kname(k), v);
        end else begin
            e = q.pop_front();
            if (e.d != d || e.k != k || e.v != v || (e.gap >= 0 && e.gap != g)) begin
                errors++;
                $display("FAIL d%0d %s: got %s v=%0h gap=%0d, want d%0d %s v=%0h gap=%0d",
                         d, kname(k), kname(k), v, g, e.d, kname(e.k), e.v, e.gap);
            end
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        cyc <= cyc + 1;
        if (on) begin
            for (int d = 0; d < 2; d++) begin
                if (br[d] != pbr[d]) see(d, K_BR, int'(br[d]));
                if (ack[d] != 4'd0)  see(d, K_ACK, int'(ack[d]));
                if (ht[d] == 2'b10)  see(d, K_NS, int'(ai[d]));
                if (ht[d] == 2'b01)  see(d, K_BUSY, int'(ai[d]));
                if (we[d] != 4'd0)   see(d, K_WE, int'(we[d]));
                if (en[d] != pen[d]) see(d, K_EN, int'(en[d]));
                if (intr[d])         see(d, K_IRQ, int'(irq[d]));
                if (snap[d])         see(d, K_SNAP, pk(d));
                pbr[d] <= br[d];
                pen[d] <= en[d];
            end
        end
        if (fin || cyc > 3000) begin
            if (!fin) begin
                errors++;
                checks++;
                $display("FAIL timeout: got cycle %0d, want stimulus finished", cyc);
            end
            while (q.size() > 0) begin
                e = q.pop_front();
                errors++;
                checks++;
                $display("FAIL missing d%0d %s: got nothing, want v=%0h", e.d, kname(e.k), e.v);
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic ex(int d, int k, int v, int g);
        ev_t e;
        e.d = d;
        e.k = k;
        e.v = v;
        e.gap = g;
        q.push_back(e);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called one cycle before the IDLE controller sees its request; returns in the
    // IDLE cycle that follows ch_done. mask is applied to the request after ReqAck.
    task automatic serve(int d, int ch, int g, logic [3:0] mask, int ws);
        ex(d, K_BR, 1, g);
        ex(d, K_ACK, 1 << ch, 0);
        ex(d, K_NS, 0, 1);
        ex(d, K_NS, 1, 1);
        ex(d, K_WE, 1, 0);
        repeat (ws) ex(d, K_BUSY, 2, 1);
        ex(d, K_NS, 2, 1);
        ex(d, K_WE, 2, 0);
        ex(d, K_NS, 3, 1);
        ex(d, K_WE, 4, 0);
        ex(d, K_WE, 8, 1);
        ex(d, K_EN, 1 << ch, 1);
        tick(2);
        req[d] = req[d] & mask;
        tick(2);
        if (ws > 0) begin
            hready[d] = 1'b0;
            tick(ws);
            hready[d] = 1'b1;
        end
        tick(5);
        ex(d, K_IRQ, ch, 2);
        ex(d, K_BR, 0, 1);
        ex(d, K_EN, 0, 0);
        done[d] = 1'b1;
        tick(1);
        done[d] = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        on  = 1'b0;
        fin = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d]    = 4'd0;
            grant[d]  = 1'b1;
            hready[d] = 1'b1;
            done[d]   = 1'b0;
            snap[d]   = 1'b0;
        end
        tick(3);
        rst = 1'b1;
        on  = 1'b1;
        ex(0, K_SNAP, 0, -1);
        ex(1, K_SNAP, 0, -1);
        snap[0] = 1'b1;
        snap[1] = 1'b1;
        tick(1);
        snap[0] = 1'b0;
        snap[1] = 1'b0;
        tick(2);

        req[0] = 4'b0100;
        serve(0, 2, -1, 4'b1011, 0);

        req[0] = 4'b1011;
        serve(0, 3, 1, 4'b0111, 0);
        serve(0, 1, 1, 4'b1101, 0);
        serve(0, 0, 1, 4'b1110, 0);

        req[0] = 4'b0001;
        serve(0, 0, 1, 4'b1110, 2);

        req[0] = 4'b0010;
        ex(0, K_BR, 1, 1);
        ex(0, K_ACK, 2, 0);
        ex(0, K_NS, 0, 1);
        ex(0, K_NS, 1, 1);
        ex(0, K_WE, 1, 0);
        ex(0, K_NS, 2, 1);
        ex(0, K_WE, 2, 0);
        ex(0, K_NS, 0, 4);
        ex(0, K_NS, 1, 1);
        ex(0, K_WE, 1, 0);
        ex(0, K_NS, 2, 1);
        ex(0, K_WE, 2, 0);
        ex(0, K_NS, 3, 1);
        ex(0, K_WE, 4, 0);
        ex(0, K_WE, 8, 1);
        ex(0, K_EN, 2, 1);
        ex(0, K_EN, 0, 2);
        ex(0, K_EN, 2, 2);
        ex(0, K_IRQ, 1, 1);
        ex(0, K_BR, 0, 1);
        ex(0, K_EN, 0, 0);
        tick(2);
        req[0] = 4'b0000;
        tick(3);
        grant[0] = 1'b0;
        tick(2);
        grant[0] = 1'b1;
        tick(7);
        grant[0] = 1'b0;
        tick(2);
        grant[0] = 1'b1;
        tick(2);
        done[0] = 1'b1;
        tick(1);
        done[0] = 1'b0;
        tick(2);

        req[1] = 4'b1111;
        serve(1, 0, -1, 4'hF, 0);
        serve(1, 1, 1, 4'hF, 0);
        serve(1, 2, 1, 4'hF, 0);
        serve(1, 3, 1, 4'hF, 0);
        serve(1, 0, 1, 4'h0, 0);

        req[1] = 4'b0100;
        ex(1, K_BR, 1, 1);
        ex(1, K_ACK, 4, 0);
        ex(1, K_NS, 0, 1);
        ex(1, K_BR, 0, 1);
        ex(1, K_SNAP, 0, 0);
        tick(2);
        req[1] = 4'b0000;
        tick(1);
        rst = 1'b0;
        snap[1] = 1'b1;
        tick(1);
        snap[1] = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        req[1] = 4'b1111;
        serve(1, 0, -1, 4'h0, 0);

        tick(3);
        fin = 1'b1;
        tick(5);
    end
endmodule
